// File: rtl/raster_scheduler_pkg.sv
// rtl/raster_scheduler_pkg.sv - shared graphics types and scheduler state encoding
package raster_scheduler_pkg;

  typedef struct packed {
    logic [7:0]  id;
    logic [11:0] v0_x;
    logic [11:0] v0_y;
    logic [11:0] v1_x;
    logic [11:0] v1_y;
    logic [11:0] v2_x;
    logic [11:0] v2_y;
  } object_t;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] z;
    logic [23:0] color;
  } pixel_info_t;

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT, DRAIN} raster_sched_state_t;

  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_scheduler_if.sv
// rtl/raster_scheduler_if.sv - object, lane and pixel stream signals of the raster scheduler
// Optional statistics outputs exist when RASTER_SCHED_STATS_EN is defined.
interface raster_scheduler_if #(parameter int NUM_LANES = 4) ();
  raster_scheduler_pkg::object_t                      obj_in;
  logic                                               obj_valid;
  logic                                               obj_ready;
  raster_scheduler_pkg::object_t                      rast_task;
  logic                                               rast_next_task;
  logic [NUM_LANES-1:0]                               rast_task_complete;
  raster_scheduler_pkg::pixel_info_t [NUM_LANES-1:0]  rast_pixel;
  logic [NUM_LANES-1:0]                               rast_write;
  raster_scheduler_pkg::pixel_info_t                  pix_out;
  logic                                               pix_valid;
  logic                                               pix_ready;
  logic                                               busy;
  logic                                               overflow_err;
`ifdef RASTER_SCHED_STATS_EN
  logic [31:0]                                        obj_count;
  logic [31:0]                                        pix_count;
  logic [15:0]                                        drop_count;

  modport master (
    input  obj_in, obj_valid, rast_task_complete, rast_pixel, rast_write, pix_ready,
    output obj_ready, rast_task, rast_next_task, pix_out, pix_valid, busy, overflow_err,
    output obj_count, pix_count, drop_count
  );
  modport slave (
    output obj_in, obj_valid, rast_task_complete, rast_pixel, rast_write, pix_ready,
    input  obj_ready, rast_task, rast_next_task, pix_out, pix_valid, busy, overflow_err,
    input  obj_count, pix_count, drop_count
  );
`else
  modport master (
    input  obj_in, obj_valid, rast_task_complete, rast_pixel, rast_write, pix_ready,
    output obj_ready, rast_task, rast_next_task, pix_out, pix_valid, busy, overflow_err
  );
  modport slave (
    output obj_in, obj_valid, rast_task_complete, rast_pixel, rast_write, pix_ready,
    input  obj_ready, rast_task, rast_next_task, pix_out, pix_valid, busy, overflow_err
  );
`endif
endinterface

// File: rtl/raster_scheduler_pixel_fifo.sv
// rtl/raster_scheduler_pixel_fifo.sv - per-lane pixel FIFO; pushes into a full FIFO are dropped
module pixel_fifo
  import raster_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  pixel_info_t data,
  input  logic        pop,
  output pixel_info_t head,
  output logic        empty,
  output logic        full,
  output logic        drop
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  pixel_info_t mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A simultaneous pop frees the slot, so a push on a full FIFO is kept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data;
  end
endmodule

// File: rtl/raster_scheduler.sv
// rtl/raster_scheduler.sv - broadcasts objects to rasterizer lanes and funnels lane pixels into one stream
// Defining RASTER_SCHED_STATS_EN adds object, pixel and drop counters.
module raster_scheduler
  import raster_scheduler_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clock,
  input logic                reset,
  raster_scheduler_if.master bus
);
  localparam int LW = lane_idx_w(NUM_LANES);

  raster_sched_state_t  state_q, state_d;
  object_t              rast_task_q, rast_task_d;
  logic                 obj_ready_q, obj_ready_d;
  logic                 next_task_q, next_task_d;
  logic [NUM_LANES-1:0] done_q, done_d;
  pixel_info_t          pix_out_q, pix_out_d;
  logic                 pix_valid_q, pix_valid_d;
  logic [LW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 overflow_q, overflow_d;

  pixel_info_t          fifo_head [NUM_LANES];
  logic [NUM_LANES-1:0] fifo_empty, fifo_full, fifo_drop, fifo_pop;
  logic                 unused_fifo_full;
  logic                 grant_valid, load;
  logic [LW-1:0]        grant_idx;
  int                   idx;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (bus.rast_write[i]),
      .data  (bus.rast_pixel[i]),
      .pop   (fifo_pop[i]),
      .head  (fifo_head[i]),
      .empty (fifo_empty[i]),
      .full  (fifo_full[i]),
      .drop  (fifo_drop[i])
    );
  end
  assign unused_fifo_full = ^fifo_full;

  // Walk from the farthest lane back to the pointer so the nearest non-empty lane wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int off = NUM_LANES - 1; off >= 0; off--) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (!fifo_empty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[LW-1:0];
      end
    end
  end

  always_comb begin
    load        = grant_valid & (~pix_valid_q | bus.pix_ready);
    fifo_pop    = '0;
    pix_out_d   = pix_out_q;
    pix_valid_d = pix_valid_q & ~bus.pix_ready;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      fifo_pop[grant_idx] = 1'b1;
      pix_out_d   = fifo_head[grant_idx];
      pix_valid_d = 1'b1;
      rr_ptr_d    = (int'(grant_idx) == NUM_LANES - 1) ? '0 : grant_idx + 1'b1;
    end
    overflow_d = overflow_q | (|fifo_drop);
  end

  always_comb begin
    state_d     = state_q;
    rast_task_d = rast_task_q;
    next_task_d = 1'b0;
    done_d      = done_q;
    case (state_q)
      IDLE: if (bus.obj_valid && obj_ready_q) begin
        rast_task_d = bus.obj_in;
        next_task_d = 1'b1;
        done_d      = '0;
        state_d     = DISPATCH;
      end
      DISPATCH: begin
        done_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        done_d = done_q | bus.rast_task_complete;
        if (&done_d) state_d = DRAIN;
      end
      DRAIN: if ((&fifo_empty) && !pix_valid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    obj_ready_d = (state_d == IDLE);
  end

`ifdef RASTER_SCHED_STATS_EN
  logic [31:0] obj_count_q, obj_count_d;
  logic [31:0] pix_count_q, pix_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic [16:0] drop_total;

  always_comb begin
    obj_count_d  = obj_count_q + {31'd0, next_task_d};
    pix_count_d  = pix_count_q + {31'd0, pix_valid_q & bus.pix_ready};
    drop_total   = {1'b0, drop_count_q} + 17'($countones(fifo_drop));
    drop_count_d = drop_total[16] ? 16'hFFFF : drop_total[15:0];
  end

  assign bus.obj_count  = obj_count_q;
  assign bus.pix_count  = pix_count_q;
  assign bus.drop_count = drop_count_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rast_task_q  <= '0;
      obj_ready_q  <= 1'b0;
      next_task_q  <= 1'b0;
      done_q       <= '0;
      pix_out_q    <= '0;
      pix_valid_q  <= 1'b0;
      rr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
`ifdef RASTER_SCHED_STATS_EN
      obj_count_q  <= '0;
      pix_count_q  <= '0;
      drop_count_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rast_task_q  <= rast_task_d;
      obj_ready_q  <= obj_ready_d;
      next_task_q  <= next_task_d;
      done_q       <= done_d;
      pix_out_q    <= pix_out_d;
      pix_valid_q  <= pix_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      overflow_q   <= overflow_d;
`ifdef RASTER_SCHED_STATS_EN
      obj_count_q  <= obj_count_d;
      pix_count_q  <= pix_count_d;
      drop_count_q <= drop_count_d;
`endif
    end
  end

  assign bus.obj_ready      = obj_ready_q;
  assign bus.rast_task      = rast_task_q;
  assign bus.rast_next_task = next_task_q;
  assign bus.pix_out        = pix_out_q;
  assign bus.pix_valid      = pix_valid_q;
  assign bus.overflow_err   = overflow_q;
  assign bus.busy           = (state_q != IDLE) | ~(&fifo_empty) | pix_valid_q;
endmodule

// File: doc/raster_scheduler.md
Name: raster_scheduler

Overview:
- Sequences a bank of NUM_LANES column-sliced rasterizers.
- Accepts triangle objects from the object queue over valid/ready and broadcasts each one to every lane. Waits until every lane has reported completion, then dispatches the next object.
- Funnels all lane pixel writes through per-lane FIFOs and a round-robin arbiter into one registered valid/ready pixel stream feeding the depth-test/framebuffer stage.

Parameters:
- NUM_LANES, 4, number of rasterizer lanes (1..16).
- FIFO_DEPTH, 4, per-lane pixel FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- obj_in  in  object_t  next object from the object queue
- obj_valid  in  1  obj_in valid
- obj_ready  out  1  object accepted on a cycle where obj_valid & obj_ready
- rast_task  out  object_t  registered task broadcast to all lanes; held stable until the next dispatch
- rast_next_task  out  1  one-cycle start pulse to all lanes
- rast_task_complete  in  NUM_LANES  per-lane completion; may be a single-cycle pulse
- rast_pixel  in  NUM_LANES x pixel_info_t  per-lane pixel data
- rast_write  in  NUM_LANES  per-lane pixel write strobe; no backpressure possible
- pix_out  out  pixel_info_t  arbitrated pixel
- pix_valid  out  1  pix_out valid
- pix_ready  in  1  downstream accepts pix_out
- busy  out  1  an object is in flight or pixels remain buffered
- overflow_err  out  1  sticky; set when a lane pixel was dropped

Behaviour:
- Clock is clock; reset is reset, asynchronous, active-high.
- Reset values: all outputs 0, rast_task all-zero, FIFOs empty, done mask 0, arbiter pointer at lane 0, state IDLE.
- State machine:
  - IDLE: obj_ready=1. On obj_valid, latch obj_in into rast_task and go to DISPATCH.
  - DISPATCH: one cycle. rast_next_task=1, done mask cleared, go to WAIT.
  - WAIT: obj_ready=0. done[i] sets on any cycle rast_task_complete[i] is high. When the mask is all ones (including bits set this cycle), go to DRAIN.
  - DRAIN: when all FIFOs are empty and no pix_valid is outstanding, go to IDLE.
- Accept-to-pulse latency: accept in cycle k, rast_task valid and rast_next_task high in cycle k+1.
- rast_task_complete asserted outside WAIT is ignored. This includes a completion in the DISPATCH cycle; the lane is expected to finish no earlier than the cycle after the pulse.
- Lane FIFOs:
  - rast_write[i] pushes rast_pixel[i] in any state.
  - A push into a full FIFO is dropped and sets overflow_err. A push and a pop on a full FIFO in the same cycle are both allowed, with no drop.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the remaining bits are equal.
- Arbiter:
  - Combinational round-robin over non-empty FIFOs, starting at the pointer.
  - Pointer moves to granted+1 mod NUM_LANES, but only when a pop occurs.
- Output stage:
  - Loads the granted FIFO head when !pix_valid | pix_ready, popping that FIFO.
  - A pixel written at edge k is on pix_out at the earliest after edge k+1.
  - pix_out holds stable while pix_valid & !pix_ready.
- busy = (state != IDLE) | any FIFO non-empty | pix_valid.
- overflow_err clears only on reset.
- Reset mid-operation: state returns to IDLE, FIFOs and the output register are flushed, and buffered pixels are lost.

Optional Feature:
- Macro: RASTER_SCHED_STATS_EN.
- When defined, adds three outputs:
  - obj_count (32 bits): objects dispatched.
  - pix_count (32 bits): pixels delivered on pix_valid & pix_ready.
  - drop_count (16 bits): dropped pixels, saturating.
- All counters reset to 0; obj_count and pix_count wrap.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- The shared graphics package holds:
  - object_t and pixel_info_t (existing definitions).
  - raster_sched_state_t enum {IDLE, DISPATCH, WAIT, DRAIN}.
- Sub-module pixel_fifo, instantiated per lane:
  - Ports: push, data, pop, head, empty, full, drop.
- The round-robin arbiter stays inline.

Test Plan:
- Single object, NUM_LANES=4, each lane raises task_complete one cycle after 10, 20, 30 and 40 cycles respectively -> exactly one rast_next_task pulse; obj_ready stays 0 until the last done and empty FIFOs; state back in IDLE; next object accepted.
- Lanes 0 and 2 each write 3 pixels in the same cycles, pix_ready=1 -> pix_out order L0,L2,L0,L2,L0,L2; 6 transfers; overflow_err=0.
- Lane 1 writes 6 consecutive pixels, FIFO_DEPTH=4, pix_ready=0 -> the output register holds 1 pixel, the FIFO holds 4, 1 pixel is dropped, overflow_err=1 and stays 1 after pix_ready returns.
- pix_ready toggles 1,0,1,0 under continuous traffic -> no pixel is duplicated or lost, and pix_out is stable while stalled.
- Reset asserted in WAIT with 3 pixels buffered -> outputs immediately 0, busy=0, obj_ready=1 after reset release.
- With RASTER_SCHED_STATS_EN: 2 objects and 5 delivered pixels -> obj_count=2, pix_count=5, drop_count=0.
